lane_path_xbar: RTL and testbench

Parametrised, pipelined inter-lane path selector for the TPU vector unit. It generalises the per-lane path select into one array-wide block. It takes every lane's source operands in a single beat and applies a lane permutation: local, rotate, broadcast or shift-with-zero-fill. It then delivers the permuted operands to the execute units through a 2-stage elastic pipeline with valid/ready back-pressure. It sits between the register-file read/rotation path and the per-lane exec units.

---
 rtl/lane_path_xbar_if.sv | 43 ++++
 rtl/lane_path_xbar.sv | 139 +++++++++++++
 tb/tb_lane_path_xbar.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_path_xbar_if.sv
// lane_path_xbar_if
//   Beat-level bus of the inter-lane path selector. It carries the upstream
//   handshake (I_Valid/O_Ready), the beat payload (mode, shift, lane mask,
//   operands) and the downstream handshake (O_Valid/I_Ready). It also carries
//   the permuted payload and the busy flag.
//
//   Modports:
//     slave  - the path selector (consumes I_*, drives O_*)
//     master - the environment around it (drives I_*, consumes O_*)
//
//   Operand packing: lane l, source s occupies bits
//   ((l*NUM_SRC+s)*WIDTH_DATA) upward, for both I_Data and O_Data.
interface lane_path_xbar_if #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_SRC     = 3,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_SHIFT = $clog2(NUM_LANES)
);

  logic                                  I_Valid;
  logic                                  O_Ready;
  logic [1:0]                            I_Mode;
  logic [WIDTH_SHIFT-1:0]                I_Shift;
  logic [NUM_LANES-1:0]                  I_Lane_Mask;
  logic [NUM_LANES*NUM_SRC*WIDTH_DATA-1:0] I_Data;

  logic                                  O_Valid;
  logic                                  I_Ready;
  logic [NUM_LANES*NUM_SRC*WIDTH_DATA-1:0] O_Data;
  logic [NUM_LANES-1:0]                  O_Lane_Mask;
  logic                                  O_Busy;

  modport slave (
    input  I_Valid, I_Mode, I_Shift, I_Lane_Mask, I_Data, I_Ready,
    output O_Ready, O_Valid, O_Data, O_Lane_Mask, O_Busy
  );

  modport master (
    output I_Valid, I_Mode, I_Shift, I_Lane_Mask, I_Data, I_Ready,
    input  O_Ready, O_Valid, O_Data, O_Lane_Mask, O_Busy
  );

endinterface

// File: rtl/lane_path_xbar.sv
// lane_path_xbar
//   Array-wide inter-lane path selector for the vector unit. It captures one
//   beat holding all lanes' source operands and applies a lane permutation:
//   LOCAL, ROTATE, BCAST or SHIFT with zero fill. The permuted operands leave
//   through a 2-stage elastic pipeline with valid/ready back-pressure.
//
//   Ports:
//     clock - system clock (single domain)
//     reset - synchronous, active-high; drops in-flight beats, clears state
//     bus   - lane_path_xbar_if.slave (handshakes, payload in and out)
//
//   Pipeline:
//     S1 registers the raw beat. The permutation is combinational from S1.
//     S2 registers the permuted beat and drives the outputs directly.
//     O_Ready depends combinationally on I_Ready only, so all three moves
//     can happen in the same cycle: S2 drain, S1->S2 advance and S1 capture.
module lane_path_xbar #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_SRC     = 3,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_SHIFT = $clog2(NUM_LANES)
) (
  input  logic                clock,
  input  logic                reset,
  lane_path_xbar_if.slave     bus
);

  localparam int LANE_W = NUM_SRC * WIDTH_DATA;   // all src channels of a lane
  localparam int BEAT_W = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    MODE_LOCAL  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BCAST  = 2'd2,
    MODE_SHIFT  = 2'd3
  } mode_e;

  // Stage 1: raw beat
  logic                   s1_valid;
  logic [BEAT_W-1:0]      s1_data;
  mode_e                  s1_mode;
  logic [WIDTH_SHIFT-1:0] s1_shift;
  logic [NUM_LANES-1:0]   s1_mask;

  // Stage 2: permuted beat
  logic                   s2_valid;
  logic [BEAT_W-1:0]      s2_data;
  logic [NUM_LANES-1:0]   s2_mask;

  logic                   s1_load;
  logic                   s2_load;

  logic [LANE_W-1:0]      s1_lane   [NUM_LANES];
  logic [LANE_W-1:0]      perm_lane [NUM_LANES];
  logic [BEAT_W-1:0]      perm_data;

  // S1 may capture whenever a stage is free or S2 drains this cycle.
  assign bus.O_Ready = !s1_valid || !s2_valid || bus.I_Ready;
  assign s1_load     = bus.I_Valid && bus.O_Ready;
  assign s2_load     = s1_valid && (!s2_valid || bus.I_Ready);

  // Source channels never cross lanes' channel boundaries, so a lane moves
  // as one LANE_W-wide group.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_pack
    assign s1_lane[l]                    = s1_data[l*LANE_W +: LANE_W];
    assign perm_data[l*LANE_W +: LANE_W] = perm_lane[l];
  end

  for (genvar d = 0; d < NUM_LANES; d++) begin : g_lane
    // One extra bit so SHIFT can tell when d+Shift runs off the top lane.
    logic [WIDTH_SHIFT:0]   sum;
    logic [WIDTH_SHIFT-1:0] src;
    logic                   src_ok;

    always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned; otherwise a latch is inferred.
      sum    = {1'b0, WIDTH_SHIFT'(d)} + {1'b0, s1_shift};
      src    = WIDTH_SHIFT'(d);
      src_ok = 1'b1;
      case (s1_mode)
        MODE_LOCAL:  src = WIDTH_SHIFT'(d);
        MODE_ROTATE: src = sum[WIDTH_SHIFT-1:0];   // wraps modulo NUM_LANES
        MODE_BCAST:  src = s1_shift;
        MODE_SHIFT: begin
          src    = sum[WIDTH_SHIFT-1:0];
          src_ok = !sum[WIDTH_SHIFT];
        end
        default:     src = WIDTH_SHIFT'(d);
      endcase
      perm_lane[d] = (src_ok && s1_mask[d]) ? s1_lane[src] : '0;
    end
  end

  // Stage 1. The payload registers hold while S1 waits on a stalled S2.
  always_ff @(posedge clock) begin
    // NOTE: the data registers are reset too, because the outputs must read
    // zero after reset rather than stale operands.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_LOCAL;
      s1_shift <= '0;
      s1_mask  <= '0;
    end else if (s1_load) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, whatever the statement order.
      s1_valid <= 1'b1;
      s1_data  <= bus.I_Data;
      s1_mode  <= mode_e'(bus.I_Mode);
      s1_shift <= bus.I_Shift;
      s1_mask  <= bus.I_Lane_Mask;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2. The outputs come straight from these registers, so they stay
  // stable while the downstream stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mask  <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= perm_data;
      s2_mask  <= s1_mask;
    end else if (bus.I_Ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.O_Valid     = s2_valid;
  assign bus.O_Data      = s2_data;
  assign bus.O_Lane_Mask = s2_mask;
  assign bus.O_Busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_lane_path_xbar.sv
// tb_lane_path_xbar
//   Self-checking bench for lane_path_xbar. A transaction-level reference
//   model keeps the accepted beats in a queue. Each beat stores its expected
//   permuted payload and its accept cycle. From that queue the bench derives
//   the expected O_Ready, O_Valid, O_Busy and output payload every cycle.
module tb_lane_path_xbar;

  localparam int N  = 16;
  localparam int NS = 3;
  localparam int W  = 32;
  localparam int WS = 4;
  localparam int LW = NS * W;
  localparam int DW = N * LW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lane_path_xbar_if #(.NUM_LANES(N), .NUM_SRC(NS), .WIDTH_DATA(W), .WIDTH_SHIFT(WS)) bus ();

  lane_path_xbar #(.NUM_LANES(N), .NUM_SRC(NS), .WIDTH_DATA(W), .WIDTH_SHIFT(WS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;
  int last_depart = -100;

  // Reference model state: beats accepted but not yet delivered.
  logic [DW-1:0]  q_data [$];
  logic [N-1:0]   q_mask [$];
  int             q_acc  [$];

  // Output-valid statistics and accept counter for the directed sequences.
  int v_count, v_first, v_last, n_acc;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Permutation defined lane by lane from the mode rules with plain integers.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] din, input int mode,
                                          input int sh, input logic [N-1:0] mask);
    logic [DW-1:0] r;
    int src;
    r = '0;
    for (int d = 0; d < N; d++) begin
      case (mode)
        0:       src = d;
        1:       src = (d + sh) % N;
        2:       src = sh;
        default: src = (d + sh < N) ? d + sh : -1;
      endcase
      if (src >= 0 && mask[d]) r[d*LW +: LW] = din[src*LW +: LW];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pattern();
    logic [DW-1:0] r;
    for (int l = 0; l < N; l++)
      for (int s = 0; s < NS; s++)
        r[(l*NS+s)*W +: W] = W'(32'h100 * l + s);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] out_op(input int l, input int s);
    return bus.O_Data[(l*NS+s)*W +: W];
  endfunction

  task automatic drive(input logic v, input int mode, input int sh,
                       input logic [N-1:0] mask, input logic [DW-1:0] data);
    bus.I_Valid     = v;
    bus.I_Mode      = 2'(mode);
    bus.I_Shift     = WS'(sh);
    bus.I_Lane_Mask = mask;
    bus.I_Data      = data;
  endtask

  // One clock cycle: compare against the model at the falling edge, then
  // apply this cycle's handshakes to the model and advance past the edge.
  task automatic tick();
    logic ev, er;
    int   avail;
    #4;
    er = (q_data.size() < 2) || bus.I_Ready;
    ev = 1'b0;
    if (q_data.size() > 0) begin
      avail = q_acc[0] + 2;
      if (last_depart + 1 > avail) avail = last_depart + 1;
      ev = (cyc >= avail);
    end
    check("o_ready", LW'(bus.O_Ready), LW'(er));
    check("o_valid", LW'(bus.O_Valid), LW'(ev));
    check("o_busy",  LW'(bus.O_Busy),  LW'(q_data.size() > 0));
    if (ev) begin
      check("o_lane_mask", LW'(bus.O_Lane_Mask), LW'(q_mask[0]));
      for (int d = 0; d < N; d++)
        check($sformatf("o_data_lane%0d", d), bus.O_Data[d*LW +: LW], q_data[0][d*LW +: LW]);
    end
    if (bus.O_Valid) begin
      if (v_count == 0) v_first = cyc;
      v_last = cyc;
      v_count++;
    end
    if (ev && bus.I_Ready) begin
      void'(q_data.pop_front());
      void'(q_mask.pop_front());
      void'(q_acc.pop_front());
      last_depart = cyc;
    end
    if (bus.I_Valid && er) begin
      q_data.push_back(model(bus.I_Data, int'(bus.I_Mode), int'(bus.I_Shift), bus.I_Lane_Mask));
      q_mask.push_back(bus.I_Lane_Mask);
      q_acc.push_back(cyc);
      n_acc++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Reset with a valid beat presented, so reset must win over the load.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
    check("rst_o_valid", LW'(bus.O_Valid), '0);
    check("rst_o_busy",  LW'(bus.O_Busy),  '0);
    check("rst_o_mask",  LW'(bus.O_Lane_Mask), '0);
    for (int d = 0; d < N; d++)
      check($sformatf("rst_o_data_lane%0d", d), bus.O_Data[d*LW +: LW], '0);
    reset = 1'b0;
    bus.I_Valid = 1'b0;
    q_data.delete();
    q_mask.delete();
    q_acc.delete();
    last_depart = -100;
    #1;
    check("rst_o_ready", LW'(bus.O_Ready), LW'(1));
  endtask

  // Send one beat with I_Ready high and stop in the cycle it must be visible.
  task automatic single(input int mode, input int sh, input logic [N-1:0] mask);
    bus.I_Ready = 1'b1;
    drive(1'b1, mode, sh, mask, pattern());
    tick();
    bus.I_Valid = 1'b0;
    tick();
    check("single_o_valid", LW'(bus.O_Valid), LW'(1));
  endtask

  initial begin
    int acc0;
    drive(1'b1, 1, 5, '1, rand_data());
    bus.I_Ready = 1'b0;
    do_reset();

    // ROTATE by 3 with the positional pattern.
    single(1, 3, 16'hFFFF);
    check("rot_l15_s2", LW'(out_op(15, 2)), LW'(32'h202));
    check("rot_l0_s0",  LW'(out_op(0, 0)),  LW'(32'h300));
    tick();

    // BCAST lane 7 into the low half only.
    single(2, 7, 16'h00FF);
    check("bcast_mask",   LW'(bus.O_Lane_Mask), LW'(16'h00FF));
    check("bcast_l3_s1",  LW'(out_op(3, 1)),    LW'(32'h701));
    check("bcast_l9",     bus.O_Data[9*LW +: LW], '0);
    tick();

    // SHIFT by the maximum distance, then by zero.
    single(3, 15, 16'hFFFF);
    check("shift15_l0_s0", LW'(out_op(0, 0)), LW'(32'hF00));
    check("shift15_l1",    bus.O_Data[1*LW +: LW], '0);
    tick();
    single(3, 0, 16'hFFFF);
    check("shift0_l5_s2",  LW'(out_op(5, 2)),  LW'(32'h502));
    check("shift0_l15_s0", LW'(out_op(15, 0)), LW'(32'hF00));
    tick();

    // Back-pressure: 5 beats, downstream stalled in cycles 2..6.
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (n_acc < 5) drive(1'b1, $urandom_range(3), $urandom_range(N-1), N'($urandom), rand_data());
      else           bus.I_Valid = 1'b0;
      bus.I_Ready = !(k >= 2 && k <= 6);
      if (k == 7) check("bp_held_beats", LW'(n_acc), LW'(2));
      tick();
    end
    check("bp_all_accepted", LW'(n_acc), LW'(5));

    // Full throughput: 32 back-to-back beats.
    v_count = 0;
    n_acc   = 0;
    acc0    = cyc;
    bus.I_Ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k < 32) drive(1'b1, $urandom_range(3), $urandom_range(N-1), N'($urandom), rand_data());
      else        bus.I_Valid = 1'b0;
      tick();
    end
    check("tp_accepted",   LW'(n_acc),   LW'(32));
    check("tp_valid_cnt",  LW'(v_count), LW'(32));
    check("tp_first",      LW'(v_first), LW'(acc0 + 2));
    check("tp_contiguous", LW'(v_last - v_first + 1), LW'(32));

    // Reset with both stages full and stalled.
    bus.I_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1, $urandom_range(N-1), '1, rand_data());
      tick();
    end
    check("pre_rst_busy", LW'(bus.O_Busy), LW'(1));
    drive(1'b1, 2, 3, '1, rand_data());
    do_reset();
    single(1, 3, 16'hFFFF);
    check("post_rst_l15_s2", LW'(out_op(15, 2)), LW'(32'h202));
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(9) < 7, $urandom_range(3), $urandom_range(N-1), N'($urandom), rand_data());
      bus.I_Ready = $urandom_range(9) < 6;
      tick();
    end
    bus.I_Valid = 1'b0;
    bus.I_Ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("drain_idle", LW'(bus.O_Busy), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
